// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute-to-memory pipeline register built as a 2-entry FIFO
// skid buffer.
//
// Branch and jump resolution happens on the way in. The branch condition,
// the target address and the misalignment check are evaluated when an entry
// is accepted. Only the memory-side fields are stored.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. valid must not depend on ready. in_ready is a decode of
// the occupancy register only. While out_valid=1 and out_ready=0, the
// presented entry does not change.
//
// Ports
//   clk, rst_n           stage clock, asynchronous active-low reset
//   in_valid / in_ready  execute-side handshake
//   alu_result, negative, zero, carry, overflow   ALU result and subtract flags
//   funct3               branch condition select
//   branch, jump, is_jalr                         control class
//   pc_plus4, pc_target  link address, PC-relative target
//   rd, reg_write, mem_read, mem_write, store_data  memory/writeback controls
//   flush                synchronous kill; beats accept and pop
//   out_valid / out_ready                        memory-side handshake
//   out_result, out_store_data, out_rd, out_reg_write, out_mem_read,
//   out_mem_write, out_misaligned               oldest buffered entry
//   redirect, redirect_pc  one-cycle fetch redirect; pc holds when idle
//   dbg_state            current occupancy state (0 EMPTY, 1 ONE, 2 TWO)
module ex_mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] alu_result,
   input  logic        negative,
   input  logic        zero,
   input  logic        carry,
   input  logic        overflow,
   input  logic [2:0]  funct3,
   input  logic        branch,
   input  logic        jump,
   input  logic        is_jalr,
   input  logic [31:0] pc_plus4,
   input  logic [31:0] pc_target,
   input  logic [4:0]  rd,
   input  logic        reg_write,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] store_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [31:0] out_store_data,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic        out_mem_read,
   output logic        out_mem_write,
   output logic        out_misaligned,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        misaligned;
   } entry_t;

   state_t state, state_next;
   entry_t head, tail;   // head is the oldest entry and drives the outputs

   logic        accept, pop;
   logic        taken, ctl_xfer, misaligned;
   logic [31:0] target;
   entry_t      new_entry;

   assign in_ready  = (state != S_TWO);
   assign out_valid = (state != S_EMPTY);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign dbg_state = state;

   // Branch resolution on the incoming instruction
   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = negative ^ overflow;
         3'b101:  taken = ~(negative ^ overflow);
         3'b110:  taken = ~carry;
         3'b111:  taken = carry;
         default: taken = 1'b0;
      endcase
   end

   assign target     = is_jalr ? {alu_result[31:1], 1'b0} : pc_target;
   assign ctl_xfer   = jump | (branch & taken);
   assign misaligned = ctl_xfer & target[1];

   // A misaligned transfer is stored with no side effects so that a later
   // stage can raise the fault. A branch never writes a register unless jump
   // is also set, in which case it behaves as a jump.
   always_comb begin
      new_entry            = '0;
      new_entry.result     = jump ? pc_plus4 : alu_result;
      new_entry.store_data = store_data;
      new_entry.rd         = rd;
      new_entry.reg_write  = reg_write & ~(branch & ~jump) & ~misaligned;
      new_entry.mem_read   = mem_read & ~misaligned;
      new_entry.mem_write  = mem_write & ~misaligned;
      new_entry.misaligned = misaligned;
   end

   // Occupancy FSM
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = S_EMPTY;
      end else begin
         case (state)
            S_EMPTY: if (accept) state_next = S_ONE;
            S_ONE: begin
               if (accept && !pop)      state_next = S_TWO;
               else if (!accept && pop) state_next = S_EMPTY;
            end
            S_TWO:   if (pop) state_next = S_ONE;
            default: state_next = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_EMPTY;
      else        state <= state_next;
   end

   // Entry storage. A new entry goes into head when head is free or
   // leaving this cycle. Otherwise it goes into tail.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
      end else if (!flush) begin
         case (state)
            S_EMPTY: if (accept) head <= new_entry;
            S_ONE: begin
               if (accept && pop) head <= new_entry;
               else if (accept)   tail <= new_entry;
            end
            S_TWO:   if (pop) head <= tail;
            default: ;
         endcase
      end
   end

   assign out_result     = head.result;
   assign out_store_data = head.store_data;
   assign out_rd         = head.rd;
   assign out_reg_write  = head.reg_write;
   assign out_mem_read   = head.mem_read;
   assign out_mem_write  = head.mem_write;
   assign out_misaligned = head.misaligned;

   // Redirect is a one-cycle pulse. redirect_pc keeps its last target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect    <= 1'b0;
         redirect_pc <= '0;
      end else begin
         redirect <= accept & ~flush & ctl_xfer & ~misaligned;
         if (accept && !flush && ctl_xfer && !misaligned)
            redirect_pc <= target;
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage. Directed cases come first, followed by
// random traffic. Every case is compared against a queue-based reference
// model.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] alu_result;
   logic        negative, zero, carry, overflow;
   logic [2:0]  funct3;
   logic        branch, jump, is_jalr;
   logic [31:0] pc_plus4, pc_target;
   logic [4:0]  rd;
   logic        reg_write, mem_read, mem_write;
   logic [31:0] store_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] out_result, out_store_data;
   logic [4:0]  out_rd;
   logic        out_reg_write, out_mem_read, out_mem_write, out_misaligned;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_result(alu_result), .negative(negative), .zero(zero),
      .carry(carry), .overflow(overflow), .funct3(funct3), .branch(branch),
      .jump(jump), .is_jalr(is_jalr), .pc_plus4(pc_plus4),
      .pc_target(pc_target), .rd(rd), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .store_data(store_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_store_data(out_store_data),
      .out_rd(out_rd), .out_reg_write(out_reg_write),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_misaligned(out_misaligned), .redirect(redirect),
      .redirect_pc(redirect_pc), .dbg_state(dbg_state)
   );

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        misaligned;
   } ent_t;

   ent_t        exp_q[$];
   logic        exp_redirect;
   logic [31:0] exp_rpc;
   int          tests = 0;
   int          fails = 0;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic model_taken();
      case (funct3)
         3'd0: return zero;
         3'd1: return !zero;
         3'd4: return negative != overflow;
         3'd5: return negative == overflow;
         3'd6: return !carry;
         3'd7: return carry;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] model_target();
      if (is_jalr) return alu_result & 32'hFFFF_FFFE;
      return pc_target;
   endfunction

   function automatic logic model_xfer();
      return jump || (branch && model_taken());
   endfunction

   function automatic ent_t model_entry();
      ent_t e;
      logic bad;
      bad          = model_xfer() && (model_target() % 4 >= 2);
      e.result     = jump ? pc_plus4 : alu_result;
      e.store_data = store_data;
      e.rd         = rd;
      e.reg_write  = !bad && reg_write && !(branch && !jump);
      e.mem_read   = !bad && mem_read;
      e.mem_write  = !bad && mem_write;
      e.misaligned = bad;
      return e;
   endfunction

   task automatic model_edge();
      logic acc, pop;
      ent_t e;
      acc = in_valid && (exp_q.size() < 2);
      pop = out_ready && (exp_q.size() > 0);
      e   = model_entry();
      exp_redirect = 1'b0;
      if (flush) begin
         exp_q.delete();
      end else begin
         if (pop) void'(exp_q.pop_front());
         if (acc) begin
            exp_q.push_back(e);
            if (model_xfer() && !e.misaligned) begin
               exp_redirect = 1'b1;
               exp_rpc      = model_target();
            end
         end
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_redirect = 1'b0;
      exp_rpc      = 32'h0;
   endtask

   // ---------------- checks ----------------
   task automatic check_outputs();
      chk("in_ready", 80'(in_ready), 80'(exp_q.size() < 2));
      chk("out_valid", 80'(out_valid), 80'(exp_q.size() > 0));
      chk("redirect", 80'(redirect), 80'(exp_redirect));
      chk("redirect_pc", 80'(redirect_pc), 80'(exp_rpc));
      if (exp_q.size() > 0)
         chk("head_entry", 80'({out_result, out_store_data, out_rd, out_reg_write,
                                out_mem_read, out_mem_write, out_misaligned}),
             80'(exp_q[0]));
   endtask

   task automatic check_reset_state();
      chk("rst_in_ready", 80'(in_ready), 80'(1));
      chk("rst_out_valid", 80'(out_valid), 80'(0));
      chk("rst_redirect", 80'(redirect), 80'(0));
      chk("rst_redirect_pc", 80'(redirect_pc), 80'(0));
      chk("rst_fields", 80'({out_result, out_store_data, out_rd, out_reg_write,
                             out_mem_read, out_mem_write, out_misaligned}), 80'(0));
      chk("rst_state", 80'(dbg_state), 80'(0));
   endtask

   // ---------------- driver ----------------
   task automatic clear_in();
      in_valid = 0; alu_result = 0; negative = 0; zero = 0; carry = 0;
      overflow = 0; funct3 = 0; branch = 0; jump = 0; is_jalr = 0;
      pc_plus4 = 0; pc_target = 0; rd = 0; reg_write = 0; mem_read = 0;
      mem_write = 0; store_data = 0; flush = 0;
   endtask

   task automatic random_in();
      in_valid   = ($urandom_range(0, 3) != 0);
      alu_result = $urandom;
      negative   = $urandom_range(0, 1);
      zero       = $urandom_range(0, 1);
      carry      = $urandom_range(0, 1);
      overflow   = $urandom_range(0, 1);
      funct3     = 3'($urandom_range(0, 7));
      branch     = $urandom_range(0, 1);
      jump       = ($urandom_range(0, 3) == 0);
      is_jalr    = $urandom_range(0, 1);
      pc_plus4   = $urandom;
      pc_target  = $urandom;
      rd         = 5'($urandom_range(0, 31));
      reg_write  = $urandom_range(0, 1);
      mem_read   = $urandom_range(0, 1);
      mem_write  = $urandom_range(0, 1);
      store_data = $urandom;
      flush      = ($urandom_range(0, 19) == 0);
      out_ready  = ($urandom_range(0, 2) != 0);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   // ---------------- sequence ----------------
   initial begin
      rst_n = 1'b0;
      out_ready = 1'b0;
      clear_in();
      model_reset();
      #12;
      check_reset_state();
      rst_n = 1'b1;

      // BEQ taken
      out_ready = 1; in_valid = 1; branch = 1; funct3 = 3'b000; zero = 1;
      pc_target = 32'h100; reg_write = 1; rd = 5'd3;
      step();
      chk("beq_redirect", 80'(redirect), 80'(1));
      chk("beq_redirect_pc", 80'(redirect_pc), 80'(32'h100));
      chk("beq_out_valid", 80'(out_valid), 80'(1));
      chk("beq_reg_write", 80'(out_reg_write), 80'(0));
      clear_in();
      step();

      // JALR: 0x209 drops bit 0, giving the aligned target 0x208
      in_valid = 1; jump = 1; is_jalr = 1; alu_result = 32'h209;
      pc_plus4 = 32'h44; rd = 5'd1; reg_write = 1;
      step();
      chk("jalr_redirect_pc", 80'(redirect_pc), 80'(32'h208));
      chk("jalr_result", 80'(out_result), 80'(32'h44));
      chk("jalr_reg_write", 80'(out_reg_write), 80'(1));
      clear_in();
      step();

      // Three back-to-back entries while the memory side stalls
      out_ready = 0; in_valid = 1; reg_write = 1;
      alu_result = 32'd1; step();
      alu_result = 32'd2; step();
      chk("b2b_full", 80'(in_ready), 80'(0));
      alu_result = 32'd3; step();
      chk("b2b_hold", 80'(out_result), 80'(32'd1));
      out_ready = 1; step();
      chk("b2b_second", 80'(out_result), 80'(32'd2));
      step();
      chk("b2b_third", 80'(out_result), 80'(32'd3));
      clear_in();
      step();
      chk("b2b_drained", 80'(out_valid), 80'(0));

      // JAL to a misaligned target
      in_valid = 1; jump = 1; pc_target = 32'h102; reg_write = 1; mem_write = 1;
      step();
      chk("jal_mis_redirect", 80'(redirect), 80'(0));
      chk("jal_mis_flag", 80'(out_misaligned), 80'(1));
      chk("jal_mis_reg_write", 80'(out_reg_write), 80'(0));
      clear_in();
      step();

      // Flush with two buffered entries and a taken BLTU arriving
      out_ready = 0; in_valid = 1; alu_result = 32'hA; step();
      alu_result = 32'hB; step();
      clear_in();
      flush = 1; in_valid = 1; branch = 1; funct3 = 3'b110; carry = 0;
      pc_target = 32'h300;
      step();
      chk("flush_out_valid", 80'(out_valid), 80'(0));
      chk("flush_redirect", 80'(redirect), 80'(0));
      chk("flush_in_ready", 80'(in_ready), 80'(1));
      clear_in();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         random_in();
         step();
      end

      // Asynchronous reset while two entries are buffered
      clear_in();
      out_ready = 0;
      step();
      in_valid = 1; alu_result = 32'h55; reg_write = 1; step();
      alu_result = 32'h66; step();
      chk("pre_reset_full", 80'(in_ready), 80'(0));
      clear_in();
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_state();
      rst_n = 1'b1;
      in_valid = 1; alu_result = 32'h77; rd = 5'd9; reg_write = 1;
      step();
      chk("post_reset_accept", 80'(out_result), 80'(32'h77));
      clear_in();
      out_ready = 1;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
